// File: rtl/cpu_types_pkg.sv
// Shared pipeline control types for the hazard/forwarding unit.
package cpu_types_pkg;

    // Pipeline latch control: advance, hold, or load a bubble.
    typedef enum logic [1:0] {
        PIPE_EN    = 2'd0,
        PIPE_STALL = 2'd1,
        PIPE_FLUSH = 2'd2
    } pipe_state_t;

    // ALU operand source.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // Hazard FSM states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    localparam int REG_W  = 5;
    localparam int BCNT_W = 3;

    // True when a valid writer targets src; $0 never matches.
    function automatic logic reg_match(logic wen, logic [REG_W-1:0] wsel,
                                       logic [REG_W-1:0] src);
        return wen && (wsel != '0) && (wsel == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side signal bundle for the hazard/forwarding unit.
interface hazard_fwd_unit_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) ();
    logic             ihit, dhit;
    logic [REG_W-1:0] de_rs, de_rt, ex_rs, ex_rt;
    logic [REG_W-1:0] ex_wsel, mem_wsel, wb_wsel;
    logic             ex_wen, mem_wen, wb_wen;
    logic             ex_ren, mem_req, br_taken, halt;
    logic             pc_wen;
    pipe_state_t      fd_state, de_state, em_state, mw_state;
    fwd_sel_t         fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             halted;

    modport hu (
        input  ihit, dhit, de_rs, de_rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel,
               ex_wen, mem_wen, wb_wen, ex_ren, mem_req, br_taken, halt,
        output pc_wen, fd_state, de_state, em_state, mw_state, fwd_a, fwd_b,
               stall_cnt, flush_cnt, halted
    );

    modport tb (
        output ihit, dhit, de_rs, de_rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel,
               ex_wen, mem_wen, wb_wen, ex_ren, mem_req, br_taken, halt,
        input  pc_wen, fd_state, de_state, em_state, mw_state, fwd_a, fwd_b,
               stall_cnt, flush_cnt, halted
    );
endinterface

// File: rtl/hazard_fwd_mux_sel.sv
// Per-operand forward select: newest producer (MEM) wins over WB.
module hazard_fwd_mux_sel
    import cpu_types_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [REG_W-1:0] src,
    input  logic             mem_wen,
    input  logic [REG_W-1:0] mem_wsel,
    input  logic             wb_wen,
    input  logic [REG_W-1:0] wb_wsel,
    output fwd_sel_t         sel
);

    // Stall-only builds always read the register file.
    always_comb begin
        sel = FWD_REG;
        if (FWD_EN != 0) begin
            if (reg_match(mem_wen, mem_wsel, src))     sel = FWD_MEM;
            else if (reg_match(wb_wen, wb_wsel, src))  sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection, latch control, forwarding and perf counters for the
// 5-stage pipeline.
module hazard_fwd_unit
    import cpu_types_pkg::*;
#(
    parameter int FWD_EN     = 1,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input logic           CLK,
    input logic           nRST,
    hazard_fwd_unit_if.hu hif
);

    localparam logic [BCNT_W-1:0] LU_INIT = BCNT_W'(LU_BUBBLES - 1);

    hz_state_t         state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic              pc_wen, flush_inc, dmem_wait, hazard, lu_active;
    pipe_state_t       fd_s, de_s, em_s, mw_s;

    hazard_fwd_mux_sel #(.FWD_EN(FWD_EN)) u_sel_a (
        .src(hif.ex_rs), .mem_wen(hif.mem_wen), .mem_wsel(hif.mem_wsel),
        .wb_wen(hif.wb_wen), .wb_wsel(hif.wb_wsel), .sel(hif.fwd_a)
    );
    hazard_fwd_mux_sel #(.FWD_EN(FWD_EN)) u_sel_b (
        .src(hif.ex_rt), .mem_wen(hif.mem_wen), .mem_wsel(hif.mem_wsel),
        .wb_wen(hif.wb_wen), .wb_wsel(hif.wb_wsel), .sel(hif.fwd_b)
    );

    // RAW detection: with forwarding only a load in EX hurts; without it any
    // in-flight writer of a decode source does.
    always_comb begin
        dmem_wait = hif.mem_req && !hif.dhit;
        if (FWD_EN != 0)
            hazard = hif.ex_ren &&
                     (reg_match(hif.ex_wen, hif.ex_wsel, hif.de_rs) ||
                      reg_match(hif.ex_wen, hif.ex_wsel, hif.de_rt));
        else
            hazard = reg_match(hif.ex_wen,  hif.ex_wsel,  hif.de_rs) ||
                     reg_match(hif.ex_wen,  hif.ex_wsel,  hif.de_rt) ||
                     reg_match(hif.mem_wen, hif.mem_wsel, hif.de_rs) ||
                     reg_match(hif.mem_wen, hif.mem_wsel, hif.de_rt) ||
                     reg_match(hif.wb_wen,  hif.wb_wsel,  hif.de_rs) ||
                     reg_match(hif.wb_wen,  hif.wb_wsel,  hif.de_rt);
        // Forwarding builds hold the bubble count regardless of inputs;
        // stall-only builds leave as soon as no writer matches.
        lu_active = ((state_q == RUN) && hazard) ||
                    ((state_q == LU_STALL) && ((FWD_EN != 0) || hazard));
    end

    // Priority-ordered latch control and FSM next state.
    always_comb begin
        pc_wen    = 1'b1;
        fd_s      = PIPE_EN;
        de_s      = PIPE_EN;
        em_s      = PIPE_EN;
        mw_s      = PIPE_EN;
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        flush_inc = 1'b0;
        if ((state_q == HALT) || hif.halt) begin
            pc_wen  = 1'b0;
            fd_s    = PIPE_STALL;
            de_s    = PIPE_STALL;
            em_s    = PIPE_STALL;
            mw_s    = PIPE_STALL;
            state_d = HALT;
        end else if (dmem_wait) begin
            pc_wen = 1'b0;
            fd_s   = PIPE_STALL;
            de_s   = PIPE_STALL;
            em_s   = PIPE_STALL;
            mw_s   = PIPE_FLUSH;
        end else if (hif.br_taken) begin
            fd_s      = PIPE_FLUSH;
            de_s      = PIPE_FLUSH;
            state_d   = RUN;
            bcnt_d    = '0;
            flush_inc = 1'b1;
        end else if (lu_active) begin
            pc_wen = 1'b0;
            fd_s   = PIPE_STALL;
            de_s   = PIPE_FLUSH;
            if (state_q == RUN) begin
                // A single-bubble forwarding stall never needs LU_STALL.
                bcnt_d  = LU_INIT;
                state_d = ((FWD_EN != 0) && (LU_INIT == '0)) ? RUN : LU_STALL;
            end else begin
                bcnt_d = (bcnt_q != '0) ? bcnt_q - 1'b1 : '0;
                if (FWD_EN != 0)
                    state_d = (bcnt_q <= BCNT_W'(1)) ? RUN : LU_STALL;
            end
        end else begin
            state_d = RUN;
            bcnt_d  = '0;
            if (!hif.ihit) begin
                pc_wen = 1'b0;
                fd_s   = PIPE_FLUSH;
            end
        end
    end

    // Saturating counters; cycles spent in HALT are not stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_wen && (state_q != HALT) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            bcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.pc_wen    = pc_wen;
    assign hif.fd_state  = fd_s;
    assign hif.de_state  = de_s;
    assign hif.em_state  = em_s;
    assign hif.mw_state  = mw_s;
    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;
    assign hif.halted    = (state_q == HALT);

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench: two builds (stall-only and forwarding) share stimulus.
module tb_hazard_fwd_unit;
    import cpu_types_pkg::*;

    typedef struct packed {
        bit       rst_n, ihit, dhit;
        bit [4:0] de_rs, de_rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel;
        bit       ex_wen, mem_wen, wb_wen, ex_ren, mem_req, br_taken, halt;
    } in_t;

    typedef struct {
        int pc, fd, de, em, mw, fa, fb, sc, fc, hl;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    in_t  cur;
    exp_t q0[$], q1[$];
    exp_t me, ma;
    int   n_chk = 0, n_fail = 0;

    // instance 0: stall-only, 3 bubbles, 8-bit counters; 1: forwarding, 2 bubbles, 4-bit
    int p_fwd[2] = '{0, 1};
    int p_lb[2]  = '{3, 2};
    int p_max[2] = '{255, 15};
    int m_halt[2], m_pend[2], m_sc[2], m_fc[2];

    always #5 CLK = ~CLK;

    hazard_fwd_unit_if #(.CNT_W(8)) if0 ();
    hazard_fwd_unit_if #(.CNT_W(4)) if1 ();

    hazard_fwd_unit #(.FWD_EN(0), .LU_BUBBLES(3), .CNT_W(8)) d0 (.CLK(CLK), .nRST(nRST), .hif(if0));
    hazard_fwd_unit #(.FWD_EN(1), .LU_BUBBLES(2), .CNT_W(4)) d1 (.CLK(CLK), .nRST(nRST), .hif(if1));

    assign nRST = cur.rst_n;
    assign if0.ihit = cur.ihit;         assign if1.ihit = cur.ihit;
    assign if0.dhit = cur.dhit;         assign if1.dhit = cur.dhit;
    assign if0.de_rs = cur.de_rs;       assign if1.de_rs = cur.de_rs;
    assign if0.de_rt = cur.de_rt;       assign if1.de_rt = cur.de_rt;
    assign if0.ex_rs = cur.ex_rs;       assign if1.ex_rs = cur.ex_rs;
    assign if0.ex_rt = cur.ex_rt;       assign if1.ex_rt = cur.ex_rt;
    assign if0.ex_wsel = cur.ex_wsel;   assign if1.ex_wsel = cur.ex_wsel;
    assign if0.mem_wsel = cur.mem_wsel; assign if1.mem_wsel = cur.mem_wsel;
    assign if0.wb_wsel = cur.wb_wsel;   assign if1.wb_wsel = cur.wb_wsel;
    assign if0.ex_wen = cur.ex_wen;     assign if1.ex_wen = cur.ex_wen;
    assign if0.mem_wen = cur.mem_wen;   assign if1.mem_wen = cur.mem_wen;
    assign if0.wb_wen = cur.wb_wen;     assign if1.wb_wen = cur.wb_wen;
    assign if0.ex_ren = cur.ex_ren;     assign if1.ex_ren = cur.ex_ren;
    assign if0.mem_req = cur.mem_req;   assign if1.mem_req = cur.mem_req;
    assign if0.br_taken = cur.br_taken; assign if1.br_taken = cur.br_taken;
    assign if0.halt = cur.halt;         assign if1.halt = cur.halt;

    function automatic in_t idle();
        in_t v = '0;
        v.rst_n = 1'b1;
        v.ihit  = 1'b1;
        v.dhit  = 1'b1;
        return v;
    endfunction

    // Does writer w feed a decode-stage source?
    function automatic bit rd(in_t v, bit [4:0] w);
        return (w != 0) && (w == v.de_rs || w == v.de_rt);
    endfunction

    function automatic int fsel(in_t v, bit [4:0] src, int fwd);
        if (fwd == 0 || src == 0)                return int'(FWD_REG);
        if (v.mem_wen && v.mem_wsel == src)      return int'(FWD_MEM);
        if (v.wb_wen && v.wb_wsel == src)        return int'(FWD_WB);
        return int'(FWD_REG);
    endfunction

    // Reference: remaining-bubble count plus a sticky halt flag.
    task automatic model(int k, in_t v);
        exp_t e;
        bit   haz, lu, br_eff = 0, masked;
        int   fwd = p_fwd[k];
        if (!v.rst_n) begin
            m_halt[k] = 0; m_pend[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
        e.fa = fsel(v, v.ex_rs, fwd);
        e.fb = fsel(v, v.ex_rt, fwd);
        e.sc = m_sc[k]; e.fc = m_fc[k]; e.hl = m_halt[k];
        if (fwd != 0) haz = v.ex_ren && v.ex_wen && rd(v, v.ex_wsel);
        else haz = (v.ex_wen && rd(v, v.ex_wsel)) || (v.mem_wen && rd(v, v.mem_wsel)) ||
                   (v.wb_wen && rd(v, v.wb_wsel));
        lu = haz || (fwd != 0 && m_pend[k] > 0);
        e.pc = 1; e.fd = int'(PIPE_EN); e.de = int'(PIPE_EN); e.em = int'(PIPE_EN); e.mw = int'(PIPE_EN);
        masked = (m_halt[k] != 0) || v.halt;
        if (masked) begin
            e.pc = 0; e.fd = int'(PIPE_STALL); e.de = int'(PIPE_STALL);
            e.em = int'(PIPE_STALL); e.mw = int'(PIPE_STALL);
        end else if (v.mem_req && !v.dhit) begin
            e.pc = 0; e.fd = int'(PIPE_STALL); e.de = int'(PIPE_STALL);
            e.em = int'(PIPE_STALL); e.mw = int'(PIPE_FLUSH);
        end else if (v.br_taken) begin
            e.fd = int'(PIPE_FLUSH); e.de = int'(PIPE_FLUSH); br_eff = 1;
        end else if (lu) begin
            e.pc = 0; e.fd = int'(PIPE_STALL); e.de = int'(PIPE_FLUSH);
        end else if (!v.ihit) begin
            e.pc = 0; e.fd = int'(PIPE_FLUSH);
        end
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        if (v.rst_n) begin
            if (e.pc == 0 && m_halt[k] == 0 && m_sc[k] < p_max[k]) m_sc[k]++;
            if (br_eff && m_fc[k] < p_max[k]) m_fc[k]++;
            if (masked) m_halt[k] = 1;
            else if (v.mem_req && !v.dhit) begin end
            else if (v.br_taken) m_pend[k] = 0;
            else if (lu && fwd != 0) m_pend[k] = (m_pend[k] > 0) ? m_pend[k] - 1 : p_lb[k] - 1;
        end
    endtask

    task automatic cycle(in_t v);
        @(posedge CLK);
        #1;
        cur = v;
        model(0, v);
        model(1, v);
    endtask

    task automatic chk(string name, int k, int act, int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got %0d expected %0d", name, k, $time, act, expv);
        end
    endtask

    task automatic cmp(int k, exp_t a, exp_t e);
        chk("pc_wen", k, a.pc, e.pc);     chk("fd_state", k, a.fd, e.fd);
        chk("de_state", k, a.de, e.de);   chk("em_state", k, a.em, e.em);
        chk("mw_state", k, a.mw, e.mw);   chk("fwd_a", k, a.fa, e.fa);
        chk("fwd_b", k, a.fb, e.fb);      chk("stall_cnt", k, a.sc, e.sc);
        chk("flush_cnt", k, a.fc, e.fc);  chk("halted", k, a.hl, e.hl);
    endtask

    // Monitor: compare presented outputs against the oldest expectation.
    always @(negedge CLK) begin
        if (q0.size() > 0) begin
            me = q0.pop_front();
            ma.pc = int'(if0.pc_wen); ma.fd = int'(if0.fd_state); ma.de = int'(if0.de_state);
            ma.em = int'(if0.em_state); ma.mw = int'(if0.mw_state); ma.fa = int'(if0.fwd_a);
            ma.fb = int'(if0.fwd_b); ma.sc = int'(if0.stall_cnt); ma.fc = int'(if0.flush_cnt);
            ma.hl = int'(if0.halted);
            cmp(0, ma, me);
        end
        if (q1.size() > 0) begin
            me = q1.pop_front();
            ma.pc = int'(if1.pc_wen); ma.fd = int'(if1.fd_state); ma.de = int'(if1.de_state);
            ma.em = int'(if1.em_state); ma.mw = int'(if1.mw_state); ma.fa = int'(if1.fwd_a);
            ma.fb = int'(if1.fwd_b); ma.sc = int'(if1.stall_cnt); ma.fc = int'(if1.flush_cnt);
            ma.hl = int'(if1.halted);
            cmp(1, ma, me);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got running expected finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t v;
        cur = idle();
        cur.rst_n = 1'b0;
        v = idle(); v.rst_n = 1'b0;
        repeat (2) cycle(v);
        // load-use on de_rs, then reset while still stalled
        v = idle(); v.ex_ren = 1; v.ex_wen = 1; v.ex_wsel = 5; v.de_rs = 5;
        repeat (2) cycle(v);
        cycle(idle());
        cycle(v);
        v.rst_n = 1'b0; cycle(v);
        cycle(idle());
        // forwarding priority and $0
        v = idle(); v.mem_wen = 1; v.wb_wen = 1; v.mem_wsel = 8; v.wb_wsel = 8; v.ex_rs = 8;
        cycle(v);
        v.wb_wsel = 0; cycle(v);
        v = idle(); v.wb_wen = 1; v.wb_wsel = 9; v.ex_rt = 9; v.ex_rs = 0; cycle(v);
        // dmem wait masks a branch, then the branch lands
        v = idle(); v.mem_req = 1; v.dhit = 0; v.br_taken = 1;
        repeat (3) cycle(v);
        v.dhit = 1; cycle(v);
        cycle(idle());
        // writer in WB, held then released
        v = idle(); v.wb_wen = 1; v.wb_wsel = 3; v.de_rt = 3; v.ex_rs = 3;
        repeat (4) cycle(v);
        v.wb_wen = 0; cycle(v);
        // imiss long enough to saturate the 4-bit counter
        v = idle(); v.ihit = 0;
        repeat (20) cycle(v);
        cycle(idle());
        // sticky halt
        v = idle(); v.halt = 1; cycle(v);
        v = idle(); v.br_taken = 1; repeat (3) cycle(v);
        v = idle(); v.rst_n = 0; cycle(v);
        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            v.rst_n    = ($urandom_range(0, 49) != 0);
            v.ihit     = ($urandom_range(0, 9) != 0);
            v.mem_req  = ($urandom_range(0, 3) == 0);
            v.dhit     = ($urandom_range(0, 3) != 0);
            v.br_taken = ($urandom_range(0, 9) == 0);
            v.halt     = ($urandom_range(0, 99) == 0);
            v.ex_ren   = ($urandom_range(0, 2) == 0);
            v.ex_wen   = 1'($urandom_range(0, 1));
            v.mem_wen  = 1'($urandom_range(0, 1));
            v.wb_wen   = 1'($urandom_range(0, 1));
            v.de_rs    = 5'($urandom_range(0, 7));
            v.de_rt    = 5'($urandom_range(0, 7));
            v.ex_rs    = 5'($urandom_range(0, 7));
            v.ex_rt    = 5'($urandom_range(0, 7));
            v.ex_wsel  = 5'($urandom_range(0, 7));
            v.mem_wsel = 5'($urandom_range(0, 7));
            v.wb_wsel  = 5'($urandom_range(0, 7));
            cycle(v);
        end
        repeat (2) @(posedge CLK);
        chk("drain", 0, q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
